// File: rtl/cbus_req_arbiter.sv
// rtl/cbus_req_arbiter.sv - round-robin arbiter and transaction sequencer for a shared cbus slave port
module cbus_req_arbiter #(
    parameter int DW         = 32,
    parameter int AW         = 16,
    parameter int NUM_OF_MST = 4,
    parameter int TIM_WID    = 8,
    parameter int TIMEOUT    = 100
) (
    input  logic                       clk,
    input  logic                       sreset_n,
    input  logic [NUM_OF_MST-1:0]      mst_req,
    input  logic [NUM_OF_MST-1:0]      mst_cmd,
    input  logic [AW*NUM_OF_MST-1:0]   mst_addr,
    input  logic [DW*NUM_OF_MST-1:0]   mst_wdata,
    output logic [NUM_OF_MST-1:0]      mst_gnt,
    output logic [NUM_OF_MST-1:0]      mst_done,
    output logic [NUM_OF_MST-1:0]      mst_err,
    output logic [DW-1:0]              mst_rdata,
    output logic                       busy,
    output logic [AW-1:0]              cbus_slv_address,
    output logic                       cbus_slv_cmd,
    output logic [DW-1:0]              cbus_slv_wdata,
    output logic                       cbus_slv_cfg_req,
    input  logic                       cbus_slv_waccept,
    input  logic                       cbus_slv_rresp,
    input  logic [DW-1:0]              cbus_slv_rdatap
);

    localparam int GW = (NUM_OF_MST > 1) ? $clog2(NUM_OF_MST) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, REQ, WAIT_ACK, RESP, ABORT} state_t;

    state_t                  state, state_nxt;
    logic [NUM_OF_MST-1:0]   eligible;
    logic [NUM_OF_MST-1:0]   win_oh;
    logic                    win_found;
    logic [GW-1:0]           win_idx;
    logic [GW-1:0]           last_grant;
    logic [AW-1:0]           win_addr;
    logic                    win_cmd;
    logic [DW-1:0]           win_wdata;
    logic [TIM_WID-1:0]      cnt;
    logic                    ack;
    logic                    cnt_last;

    // The master finishing this cycle is masked so a held request is not re-granted at once.
    assign eligible = mst_req & ~mst_done;
    assign ack      = cbus_slv_waccept | cbus_slv_rresp;
    assign cnt_last = (cnt == TIM_WID'(TIMEOUT - 1));
    assign busy     = (state != IDLE);

    always_comb begin : pick_winner
        int            idx;
        logic [GW-1:0] sel;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        sel       = '0;
        for (int i = 0; i < NUM_OF_MST; i++) begin
            idx = int'(last_grant) + 1 + i;
            if (idx >= NUM_OF_MST) idx = idx - NUM_OF_MST;
            sel = GW'(idx);
            if (!win_found && eligible[sel]) begin
                win_found = 1'b1;
                win_idx   = sel;
            end
        end
    end

    always_comb begin : winner_fields
        win_oh    = '0;
        win_addr  = '0;
        win_cmd   = 1'b0;
        win_wdata = '0;
        for (int i = 0; i < NUM_OF_MST; i++) begin
            if (win_idx == GW'(i)) begin
                win_oh[i] = 1'b1;
                win_addr  = mst_addr[AW*i +: AW];
                win_cmd   = mst_cmd[i];
                win_wdata = mst_wdata[DW*i +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!sreset_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (win_found) state_nxt = SETUP;
            SETUP:    state_nxt = REQ;
            REQ:      state_nxt = WAIT_ACK;
            // Ack takes priority over a coincident timeout.
            WAIT_ACK: if (ack)           state_nxt = RESP;
                      else if (cnt_last) state_nxt = ABORT;
            RESP:     state_nxt = IDLE;
            ABORT:    state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sreset_n) begin
            mst_gnt          <= '0;
            mst_done         <= '0;
            mst_err          <= '0;
            mst_rdata        <= '0;
            cbus_slv_address <= '0;
            cbus_slv_cmd     <= 1'b0;
            cbus_slv_wdata   <= '0;
            cbus_slv_cfg_req <= 1'b0;
            last_grant       <= GW'(NUM_OF_MST - 1);
            cnt              <= '0;
        end else begin
            mst_done         <= '0;
            mst_err          <= '0;
            cbus_slv_cfg_req <= (state == SETUP);
            case (state)
                IDLE: begin
                    if (win_found) begin
                        cbus_slv_address <= win_addr;
                        cbus_slv_cmd     <= win_cmd;
                        cbus_slv_wdata   <= win_wdata;
                        mst_gnt          <= win_oh;
                        last_grant       <= win_idx;
                    end
                end
                REQ:      cnt <= '0;
                WAIT_ACK: if (!ack && !cnt_last) cnt <= cnt + 1'b1;
                RESP: begin
                    mst_rdata <= cbus_slv_rdatap;
                    mst_done  <= mst_gnt;
                    mst_gnt   <= '0;
                end
                ABORT: begin
                    mst_rdata <= {DW{1'b1}};
                    mst_done  <= mst_gnt;
                    mst_err   <= mst_gnt;
                    mst_gnt   <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cbus_req_arbiter.sv
// tb/tb_cbus_req_arbiter.sv - self-checking bench for cbus_req_arbiter with a transaction-level model
module tb_cbus_req_arbiter;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int NM = 4;
    localparam int TW = 8;
    localparam int TO = 100;

    logic               clk = 1'b0;
    logic               sreset_n;
    logic [NM-1:0]      mst_req, mst_cmd;
    logic [AW*NM-1:0]   mst_addr;
    logic [DW*NM-1:0]   mst_wdata;
    logic [NM-1:0]      mst_gnt, mst_done, mst_err;
    logic [DW-1:0]      mst_rdata;
    logic               busy;
    logic [AW-1:0]      cbus_slv_address;
    logic               cbus_slv_cmd;
    logic [DW-1:0]      cbus_slv_wdata;
    logic               cbus_slv_cfg_req;
    logic               cbus_slv_waccept, cbus_slv_rresp;
    logic [DW-1:0]      cbus_slv_rdatap;

    cbus_req_arbiter #(.DW(DW), .AW(AW), .NUM_OF_MST(NM), .TIM_WID(TW), .TIMEOUT(TO)) dut (
        .clk(clk), .sreset_n(sreset_n),
        .mst_req(mst_req), .mst_cmd(mst_cmd), .mst_addr(mst_addr), .mst_wdata(mst_wdata),
        .mst_gnt(mst_gnt), .mst_done(mst_done), .mst_err(mst_err), .mst_rdata(mst_rdata),
        .busy(busy),
        .cbus_slv_address(cbus_slv_address), .cbus_slv_cmd(cbus_slv_cmd),
        .cbus_slv_wdata(cbus_slv_wdata), .cbus_slv_cfg_req(cbus_slv_cfg_req),
        .cbus_slv_waccept(cbus_slv_waccept), .cbus_slv_rresp(cbus_slv_rresp),
        .cbus_slv_rdatap(cbus_slv_rdatap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mst_req = '0; mst_cmd = '0; mst_addr = '0; mst_wdata = '0;
        cbus_slv_waccept = 1'b0; cbus_slv_rresp = 1'b0; cbus_slv_rdatap = '0;
    endtask

    task automatic do_reset();
        sreset_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        sreset_n = 1'b1;
    endtask

    task automatic check_all_zero(input string nm);
        check_eq({nm, " gnt"},  64'(mst_gnt), 64'(0));
        check_eq({nm, " done"}, 64'(mst_done), 64'(0));
        check_eq({nm, " err"},  64'(mst_err), 64'(0));
        check_eq({nm, " rdata"}, 64'(mst_rdata), 64'(0));
        check_eq({nm, " busy"}, 64'(busy), 64'(0));
        check_eq({nm, " cfg_req"}, 64'(cbus_slv_cfg_req), 64'(0));
        check_eq({nm, " addr"}, 64'(cbus_slv_address), 64'(0));
        check_eq({nm, " cmd"},  64'(cbus_slv_cmd), 64'(0));
        check_eq({nm, " wdata"}, 64'(cbus_slv_wdata), 64'(0));
    endtask

    // One isolated transaction; d = ack offset from the first WAIT_ACK cycle, -1 = never ack.
    task automatic single_txn(input int m, input logic wr, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wd, input int d, input logic [DW-1:0] rdp,
                              input string nm);
        int            done_c, ack_c;
        logic [NM-1:0] oh;
        oh     = NM'(1) << m;
        done_c = (d < 0) ? 4 + TO : 5 + d;
        ack_c  = (d < 0) ? -100 : 3 + d;
        mst_req = oh;
        mst_cmd[m] = wr;
        mst_addr[AW*m +: AW] = addr;
        mst_wdata[DW*m +: DW] = wd;
        cbus_slv_rdatap = rdp;
        for (int c = 1; c <= done_c + 7; c++) begin
            tick();
            cbus_slv_waccept = ((c == ack_c) && wr) || (c == done_c + 6);
            cbus_slv_rresp   = (c == ack_c) && !wr;
            if (c > done_c) mst_req = '0;
            check_eq($sformatf("%s c%0d gnt", nm, c), 64'(mst_gnt), 64'((c < done_c) ? oh : '0));
            check_eq($sformatf("%s c%0d busy", nm, c), 64'(busy), 64'(c < done_c));
            check_eq($sformatf("%s c%0d cfg_req", nm, c), 64'(cbus_slv_cfg_req), 64'(c == 2));
            check_eq($sformatf("%s c%0d done", nm, c), 64'(mst_done), 64'((c == done_c) ? oh : '0));
            check_eq($sformatf("%s c%0d err", nm, c), 64'(mst_err),
                     64'((c == done_c && d < 0) ? oh : '0));
            if (c == 1) begin
                check_eq({nm, " addr"}, 64'(cbus_slv_address), 64'(addr));
                check_eq({nm, " cmd"}, 64'(cbus_slv_cmd), 64'(wr));
                check_eq({nm, " wdata"}, 64'(cbus_slv_wdata), 64'(wd));
            end
            if (c == done_c && (d < 0 || !wr))
                check_eq({nm, " rdata"}, 64'(mst_rdata), 64'((d < 0) ? {DW{1'b1}} : rdp));
        end
    endtask

    // Transaction-level reference model state
    int            cyc;
    bit            m_active, m_to, m_cmd, rd_known;
    int            m_cur, m_t, m_ack, m_done, m_last;
    int            last_done [NM];
    logic [DW-1:0] m_rd_pend, exp_rd, exp_wd;
    logic [AW-1:0] exp_addr;
    logic          exp_cmd;
    logic [NM-1:0] prev_gnt;
    int            gnt_q[$];

    task automatic model_reset();
        cyc = 0; m_active = 0; m_to = 0; m_cmd = 0; rd_known = 1;
        m_cur = 0; m_t = 0; m_ack = 0; m_done = 0; m_last = NM - 1;
        for (int i = 0; i < NM; i++) last_done[i] = -10;
        m_rd_pend = '0; exp_rd = '0; exp_wd = '0; exp_addr = '0; exp_cmd = 1'b0;
        prev_gnt = '0;
        gnt_q.delete();
    endtask

    task automatic new_fields(input int m);
        mst_cmd[m] = 1'($urandom_range(0, 1));
        mst_addr[AW*m +: AW] = AW'($urandom);
        mst_wdata[DW*m +: DW] = $urandom;
    endtask

    task automatic run_model(input int ncyc, input bit mode_all);
        int            rel, w, d, r;
        bit            in_tx, is_done, wait_win, found;
        logic [NM-1:0] exp_oh, elig;
        for (int k = 0; k < ncyc; k++) begin
            tick();
            cyc++;
            rel     = cyc - m_t;
            exp_oh  = m_active ? (NM'(1) << m_cur) : '0;
            in_tx   = m_active && rel >= 1 && cyc < m_done;
            is_done = m_active && cyc == m_done;
            if (is_done) begin
                rd_known = m_to || !m_cmd;
                exp_rd   = m_to ? {DW{1'b1}} : m_rd_pend;
            end
            check_eq($sformatf("rnd c%0d gnt", cyc), 64'(mst_gnt), 64'(in_tx ? exp_oh : '0));
            check_eq($sformatf("rnd c%0d busy", cyc), 64'(busy), 64'(in_tx));
            check_eq($sformatf("rnd c%0d cfg_req", cyc), 64'(cbus_slv_cfg_req), 64'(m_active && rel == 2));
            check_eq($sformatf("rnd c%0d done", cyc), 64'(mst_done), 64'(is_done ? exp_oh : '0));
            check_eq($sformatf("rnd c%0d err", cyc), 64'(mst_err), 64'((is_done && m_to) ? exp_oh : '0));
            check_eq($sformatf("rnd c%0d addr", cyc), 64'(cbus_slv_address), 64'(exp_addr));
            check_eq($sformatf("rnd c%0d cmd", cyc), 64'(cbus_slv_cmd), 64'(exp_cmd));
            check_eq($sformatf("rnd c%0d wdata", cyc), 64'(cbus_slv_wdata), 64'(exp_wd));
            if (rd_known) check_eq($sformatf("rnd c%0d rdata", cyc), 64'(mst_rdata), 64'(exp_rd));
            if (mst_gnt != '0 && prev_gnt == '0)
                for (int i = 0; i < NM; i++) if (mst_gnt[i]) gnt_q.push_back(i);
            prev_gnt = mst_gnt;

            if (is_done) begin
                m_active = 0;
                last_done[m_cur] = cyc;
            end

            // Responder: ack on the planned cycle, hold read data through RESP, else stray acks
            cbus_slv_waccept = 1'b0;
            cbus_slv_rresp   = 1'b0;
            wait_win = m_active && rel >= 3 && (m_to ? (rel <= 2 + TO) : (cyc <= m_ack));
            if (m_active && !m_to && cyc == m_ack) begin
                if (m_cmd) cbus_slv_waccept = 1'b1;
                else       cbus_slv_rresp   = 1'b1;
                cbus_slv_rdatap = $urandom;
                m_rd_pend = cbus_slv_rdatap;
            end else if (m_active && !m_to && cyc == m_ack + 1) begin
                cbus_slv_rdatap = m_rd_pend;
            end else begin
                cbus_slv_rdatap = $urandom;
                if (!mode_all && !wait_win && $urandom_range(0, 7) == 0) begin
                    if ($urandom_range(0, 1) == 1) cbus_slv_waccept = 1'b1;
                    else                           cbus_slv_rresp   = 1'b1;
                end
            end

            for (int m = 0; m < NM; m++) begin
                if (m_active && m == m_cur) begin
                    if (!mode_all && mst_req[m] && $urandom_range(0, 15) == 0) mst_req[m] = 1'b0;
                end else if (mst_req[m]) begin
                    if (last_done[m] == cyc - 1) begin
                        if (mode_all || $urandom_range(0, 1) == 1) new_fields(m);
                        else mst_req[m] = 1'b0;
                    end
                end else if (last_done[m] != cyc && (mode_all || $urandom_range(0, 2) == 0)) begin
                    mst_req[m] = 1'b1;
                    new_fields(m);
                end
            end

            if (!m_active) begin
                elig = mst_req;
                for (int i = 0; i < NM; i++) if (last_done[i] == cyc) elig[i] = 1'b0;
                found = 0;
                w = 0;
                for (int j = 1; j <= NM; j++) begin
                    if (!found && elig[(m_last + j) % NM]) begin
                        found = 1;
                        w = (m_last + j) % NM;
                    end
                end
                if (found) begin
                    m_active = 1; m_cur = w; m_t = cyc; m_last = w;
                    m_cmd    = mst_cmd[w];
                    exp_cmd  = mst_cmd[w];
                    exp_addr = mst_addr[AW*w +: AW];
                    exp_wd   = mst_wdata[DW*w +: DW];
                    m_to = 0;
                    d = 0;
                    if (!mode_all) begin
                        r = $urandom_range(0, 15);
                        if (r == 0)      m_to = 1;
                        else if (r == 1) d = TO - 1;
                        else             d = $urandom_range(0, 5);
                    end
                    m_ack  = cyc + 3 + d;
                    m_done = m_to ? cyc + 4 + TO : cyc + 5 + d;
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check_all_zero("reset");

        single_txn(1, 1'b0, 16'h2004, 32'h0, 1, 32'hCAFE0001, "rd_m1");
        single_txn(0, 1'b1, 16'h4010, 32'h12345678, 0, 32'h0BADF00D, "wr_m0");
        single_txn(3, 1'b0, 16'h0BAD, 32'h0, -1, 32'h5555AAAA, "timeout_m3");
        single_txn(2, 1'b0, 16'h0123, 32'h0, TO - 1, 32'h00C0FFEE, "ack_at_limit");

        // Reset in WAIT_ACK: outputs clear next cycle, no completion afterwards
        mst_req = 4'b0100;
        mst_cmd[2] = 1'b1;
        mst_addr[AW*2 +: AW] = 16'h1234;
        mst_wdata[DW*2 +: DW] = 32'hDEADBEEF;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 3) check_eq("rst_mid busy", 64'(busy), 64'(1));
            if (c == 4) sreset_n = 1'b0;
        end
        tick();
        check_all_zero("rst_mid");
        sreset_n = 1'b1;
        mst_req = '0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_eq($sformatf("rst_mid post%0d done", c), 64'(mst_done), 64'(0));
            check_eq($sformatf("rst_mid post%0d busy", c), 64'(busy), 64'(0));
        end

        // All masters requesting continuously, starting from the post-reset pointer
        model_reset();
        run_model(30, 1'b1);
        check_eq("rr grant count", 64'(gnt_q.size() >= 5), 64'(1));
        if (gnt_q.size() >= 5) begin
            check_eq("rr grant0", 64'(gnt_q[0]), 64'(0));
            check_eq("rr grant1", 64'(gnt_q[1]), 64'(1));
            check_eq("rr grant2", 64'(gnt_q[2]), 64'(2));
            check_eq("rr grant3", 64'(gnt_q[3]), 64'(3));
            check_eq("rr grant4", 64'(gnt_q[4]), 64'(0));
        end

        run_model(4000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
